// File: rtl/fe_capture_packer_pkg.sv
// Shared capture-entry commands, FSM states and the one-slot event record.
// Combinational helpers only; no latency, no backpressure.
package fe_capture_packer_pkg;

  typedef enum logic [1:0] {
    FE_FIFO_CMD_DATA = 2'd0,
    FE_FIFO_CMD_STAT = 2'd1,
    FE_FIFO_CMD_TIME = 2'd2
  } fe_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_TIME_PEND = 2'd2,
    ST_DONE      = 2'd3
  } fe_state_e;

  typedef struct packed {
    logic       is_data;
    logic [7:0] data;
    logic [4:0] stat;
  } fe_evt_t;

  // A status-only event carries a zero data byte.
  function automatic fe_evt_t make_evt(logic is_data, logic [7:0] data, logic [4:0] stat);
    fe_evt_t e;
    e.is_data = is_data;
    e.data    = is_data ? data : 8'h00;
    e.stat    = stat;
    return e;
  endfunction

  function automatic fe_cmd_e evt_cmd(fe_evt_t e);
    return e.is_data ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
  endfunction

endpackage

// File: rtl/fe_capture_packer_if.sv
// Sniff-event inputs, capture controls and capture-entry outputs of the packer.
// Wires only; FIFO-full is the sole backpressure and is level-sampled by the packer.
interface fe_capture_packer_if #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16
);
  logic                             I_arm;
  logic [15:0]                      I_capture_len;
  logic                             I_timestamps_disable;
  logic                             I_fifo_full;
  logic [7:0]                       I_data;
  logic                             I_data_valid;
  logic [4:0]                       I_stat;
  logic                             I_stat_valid;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] O_capture_time;
  logic [7:0]                       O_capture_data;
  logic [4:0]                       O_capture_stat;
  logic [1:0]                       O_capture_cmd;
  logic                             O_capture_data_wr;
  logic                             O_capturing;
  logic                             O_capture_done;
  logic                             O_overflow;

  modport master (
    output I_arm, I_capture_len, I_timestamps_disable, I_fifo_full,
           I_data, I_data_valid, I_stat, I_stat_valid,
    input  O_capture_time, O_capture_data, O_capture_stat, O_capture_cmd,
           O_capture_data_wr, O_capturing, O_capture_done, O_overflow
  );

  modport slave (
    input  I_arm, I_capture_len, I_timestamps_disable, I_fifo_full,
           I_data, I_data_valid, I_stat, I_stat_valid,
    output O_capture_time, O_capture_data, O_capture_stat, O_capture_cmd,
           O_capture_data_wr, O_capturing, O_capture_done, O_overflow
  );
endinterface

// File: rtl/fe_capture_packer_delta_timer.sv
// Saturating cycles-since-last-entry counter with clear, all-ones and short-fits flags.
// Count updates every cycle; clear wins; holds at all-ones until cleared.
module pw_delta_timer #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [W-1:0] delta,
  output logic         all_ones,
  output logic         short_fits
);

  assign all_ones   = &delta;
  assign short_fits = ~|delta[W-1:SW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta <= '0;
    end else if (clr) begin
      delta <= '0;
    end else if (!all_ones) begin
      delta <= delta + W'(1);
    end
  end

endmodule

// File: rtl/fe_capture_packer.sv
// Packs sniff events into timestamped DATA/STAT/TIME entries; entry strobed 1 cycle after the event (2 if a TIME entry goes first).
// FIFO-full is checked on the deciding cycle: the entry is dropped and O_overflow set, nothing is retried.
module fe_capture_packer
  import fe_capture_packer_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
  input logic               fe_clk,
  input logic               reset_n,
  fe_capture_packer_if.slave cap
);

  localparam int TW = pTIMESTAMP_FULL_WIDTH;

  fe_state_e   state;
  fe_evt_t     held;
  logic [15:0] entry_cnt;
  logic [TW-1:0] delta;
  logic        delta_all_ones, delta_short_fits, delta_clr;

  fe_evt_t     ev;
  logic        ev_vld, ts_en, start;
  logic        emit_vld, wr, drop, to_pend, done_hit;
  fe_cmd_e     emit_cmd;
  logic [TW-1:0] emit_time;
  fe_evt_t     emit_evt;

  assign ev     = make_evt(cap.I_data_valid, cap.I_data, cap.I_stat);
  assign ev_vld = cap.I_data_valid | cap.I_stat_valid;
  assign ts_en  = ~cap.I_timestamps_disable;
  assign start  = (state == ST_IDLE) && cap.I_arm;

  pw_delta_timer #(.W(TW), .SW(pTIMESTAMP_SHORT_WIDTH)) u_delta (
    .clk        (fe_clk),
    .rst_n      (reset_n),
    .clr        (delta_clr),
    .delta      (delta),
    .all_ones   (delta_all_ones),
    .short_fits (delta_short_fits)
  );

  always_comb begin
    emit_vld  = 1'b0;
    emit_cmd  = FE_FIFO_CMD_DATA;
    emit_time = '0;
    emit_evt  = '0;
    to_pend   = 1'b0;
    drop      = 1'b0;
    if (cap.I_arm) begin
      case (state)
        ST_CAPTURE: begin
          if (ev_vld) begin
            emit_vld = 1'b1;
            if (ts_en && !delta_short_fits) begin
              // Delta too wide for the entry: emit it as TIME and park the event.
              emit_cmd  = FE_FIFO_CMD_TIME;
              emit_time = delta;
              to_pend   = 1'b1;
            end else begin
              emit_cmd  = evt_cmd(ev);
              emit_time = ts_en ? delta : '0;
              emit_evt  = ev;
            end
          end else if (ts_en && delta_all_ones) begin
            emit_vld  = 1'b1;
            emit_cmd  = FE_FIFO_CMD_TIME;
            emit_time = delta;
          end
        end
        ST_TIME_PEND: begin
          emit_vld = 1'b1;
          emit_cmd = evt_cmd(held);
          emit_evt = held;
          drop     = ev_vld;
        end
        default: ;
      endcase
    end
    wr        = emit_vld && !cap.I_fifo_full;
    drop      = drop || (emit_vld && cap.I_fifo_full);
    delta_clr = wr || start;
    done_hit  = wr && (emit_cmd == FE_FIFO_CMD_DATA) && (cap.I_capture_len != 16'd0) &&
                ((entry_cnt + 16'd1) == cap.I_capture_len);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      held                  <= '0;
      entry_cnt             <= '0;
      cap.O_capture_time    <= '0;
      cap.O_capture_data    <= '0;
      cap.O_capture_stat    <= '0;
      cap.O_capture_cmd     <= '0;
      cap.O_capture_data_wr <= 1'b0;
      cap.O_capturing       <= 1'b0;
      cap.O_capture_done    <= 1'b0;
      cap.O_overflow        <= 1'b0;
    end else begin
      cap.O_capture_data_wr <= wr;
      if (wr) begin
        cap.O_capture_time <= emit_time;
        cap.O_capture_data <= emit_evt.data;
        cap.O_capture_stat <= emit_evt.stat;
        cap.O_capture_cmd  <= emit_cmd;
      end
      if (wr && (emit_cmd == FE_FIFO_CMD_DATA)) entry_cnt <= entry_cnt + 16'd1;
      if (drop) cap.O_overflow <= 1'b1;
      if (to_pend) held <= ev;

      if (!cap.I_arm) begin
        state              <= ST_IDLE;
        cap.O_capturing    <= 1'b0;
        cap.O_capture_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state           <= ST_CAPTURE;
            cap.O_capturing <= 1'b1;
            entry_cnt       <= '0;
            cap.O_overflow  <= 1'b0;
          end
          ST_CAPTURE, ST_TIME_PEND: begin
            if (done_hit) begin
              state              <= ST_DONE;
              cap.O_capturing    <= 1'b0;
              cap.O_capture_done <= 1'b1;
            end else if (to_pend) begin
              state <= ST_TIME_PEND;
            end else begin
              state <= ST_CAPTURE;
            end
          end
          default: state <= ST_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fe_capture_packer.sv
// Directed, table-driven bench for fe_capture_packer plus keep-alive and async-reset sequences.
module tb_fe_capture_packer;
  import fe_capture_packer_pkg::*;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;
  always #5 fe_clk = ~fe_clk;

  fe_capture_packer_if #(.pTIMESTAMP_FULL_WIDTH(16)) cap ();

  fe_capture_packer #(.pTIMESTAMP_FULL_WIDTH(16), .pTIMESTAMP_SHORT_WIDTH(3)) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .cap     (cap)
  );

  typedef struct {
    string       name;
    int          gap;
    logic        arm, tsd;
    logic [15:0] len;
    logic        full, dv;
    logic [7:0]  d;
    logic        sv;
    logic [4:0]  s;
    logic        e_wr;
    logic [1:0]  e_cmd;
    logic [15:0] e_time;
    logic [7:0]  e_d;
    logic [4:0]  e_s;
    logic        e_cap, e_done, e_ov;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  localparam logic [1:0] D = 2'd0, S = 2'd1, T = 2'd2;

  function automatic vec_t V(string name, int gap, logic arm, logic tsd, logic [15:0] len,
                             logic full, logic dv, logic [7:0] d, logic sv, logic [4:0] s,
                             logic e_wr, logic [1:0] e_cmd, logic [15:0] e_time, logic [7:0] e_d,
                             logic [4:0] e_s, logic e_cap, logic e_done, logic e_ov);
    vec_t v;
    v.name = name; v.gap = gap; v.arm = arm; v.tsd = tsd; v.len = len; v.full = full;
    v.dv = dv; v.d = d; v.sv = sv; v.s = s; v.e_wr = e_wr; v.e_cmd = e_cmd; v.e_time = e_time;
    v.e_d = e_d; v.e_s = e_s; v.e_cap = e_cap; v.e_done = e_done; v.e_ov = e_ov;
    return v;
  endfunction

  function automatic logic [34:0] obs();
    return {cap.O_capture_data_wr, cap.O_capture_cmd, cap.O_capture_time, cap.O_capture_data,
            cap.O_capture_stat, cap.O_capturing, cap.O_capture_done, cap.O_overflow};
  endfunction

  function automatic string fmt(logic [34:0] x);
    return $sformatf("wr=%0b cmd=%0d time=%h data=%h stat=%h cap=%0b done=%0b ov=%0b",
                     x[34], x[33:32], x[31:16], x[15:8], x[7:3], x[2], x[1], x[0]);
  endfunction

  task automatic check(string name, logic [34:0] got, logic [34:0] exp, logic [34:0] mask);
    n_vec++;
    if ((got & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic set_ctl(logic arm, logic tsd, logic [15:0] len);
    cap.I_arm = arm; cap.I_timestamps_disable = tsd; cap.I_capture_len = len;
    cap.I_fifo_full = 1'b0; cap.I_data_valid = 1'b0; cap.I_stat_valid = 1'b0;
    cap.I_data = 8'h00; cap.I_stat = 5'h00;
  endtask

  // Caller sits just after a falling edge; every check samples on a falling edge.
  task automatic run_vec(vec_t v);
    int stray = 0;
    set_ctl(v.arm, v.tsd, v.len);
    for (int i = 0; i < v.gap; i++) begin
      @(posedge fe_clk); @(negedge fe_clk);
      if (cap.O_capture_data_wr) stray++;
    end
    if (v.gap > 0) check_int({v.name, "_gap_strobes"}, stray, 0);
    cap.I_fifo_full = v.full; cap.I_data_valid = v.dv; cap.I_data = v.d;
    cap.I_stat_valid = v.sv; cap.I_stat = v.s;
    @(posedge fe_clk); @(negedge fe_clk);
    check(v.name, obs(),
          {v.e_wr, v.e_cmd, v.e_time, v.e_d, v.e_s, v.e_cap, v.e_done, v.e_ov},
          v.e_wr ? {35{1'b1}} : {1'b1, 31'd0, 3'b111});
    cap.I_fifo_full = 1'b0; cap.I_data_valid = 1'b0; cap.I_stat_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    //          name           gap arm tsd len full dv d    sv s      wr cmd time  d     s     cap dn ov
    vecs.push_back(V("arm",        0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("data_t2",    2, 1, 0, 0, 0, 1, 8'hA5, 0, 5'h03,  1, D, 2,  8'hA5, 5'h03, 1, 0, 0));
    vecs.push_back(V("long_time", 20, 1, 0, 0, 0, 1, 8'h3C, 0, 5'h01,  1, T, 20, 8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("long_data",  0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  1, D, 0,  8'h3C, 5'h01, 1, 0, 0));
    vecs.push_back(V("merge",      2, 1, 0, 0, 0, 1, 8'h5A, 1, 5'h1F,  1, D, 2,  8'h5A, 5'h1F, 1, 0, 0));
    vecs.push_back(V("stat_only",  3, 1, 0, 0, 0, 0, 8'hFF, 1, 5'h0A,  1, S, 3,  8'h00, 5'h0A, 1, 0, 0));
    vecs.push_back(V("short_max",  7, 1, 0, 0, 0, 1, 8'h11, 0, 5'h00,  1, D, 7,  8'h11, 5'h00, 1, 0, 0));
    vecs.push_back(V("short_over", 8, 1, 0, 0, 0, 0, 8'h00, 1, 5'h04,  1, T, 8,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("held_stat",  0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  1, S, 0,  8'h00, 5'h04, 1, 0, 0));
    vecs.push_back(V("pend_a",     8, 1, 0, 0, 0, 1, 8'h33, 0, 5'h00,  1, T, 8,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("pend_drop",  0, 1, 0, 0, 0, 1, 8'h44, 0, 5'h00,  1, D, 0,  8'h33, 5'h00, 1, 0, 1));
    vecs.push_back(V("disarm",     0, 0, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 0, 0, 1));
    vecs.push_back(V("rearm",      0, 1, 0, 3, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("len_d1",     2, 1, 0, 3, 0, 1, 8'h01, 0, 5'h00,  1, D, 2,  8'h01, 5'h00, 1, 0, 0));
    vecs.push_back(V("full_drop",  2, 1, 0, 3, 1, 1, 8'h02, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 1));
    vecs.push_back(V("stat_delta", 1, 1, 0, 3, 0, 0, 8'h00, 1, 5'h07,  1, S, 4,  8'h00, 5'h07, 1, 0, 1));
    vecs.push_back(V("len_d2",     2, 1, 0, 3, 0, 1, 8'h03, 0, 5'h00,  1, D, 2,  8'h03, 5'h00, 1, 0, 1));
    vecs.push_back(V("len_s2",     2, 1, 0, 3, 0, 0, 8'h00, 1, 5'h08,  1, S, 2,  8'h00, 5'h08, 1, 0, 1));
    vecs.push_back(V("len_d3",     2, 1, 0, 3, 0, 1, 8'h04, 0, 5'h00,  1, D, 2,  8'h04, 5'h00, 0, 1, 1));
    vecs.push_back(V("done_ign",   2, 1, 0, 3, 0, 1, 8'h05, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 0, 1, 1));
    vecs.push_back(V("done_exit",  0, 0, 0, 3, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 0, 0, 1));
    vecs.push_back(V("arm2",       0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("pend_t10",  10, 1, 0, 0, 0, 1, 8'h66, 0, 5'h00,  1, T, 10, 8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("pend_disarm",0, 0, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 0, 0, 0));
    vecs.push_back(V("arm3",       0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("no_held",    3, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00,  0, D, 0,  8'h00, 5'h00, 1, 0, 0));
    vecs.push_back(V("ts_dis",    12, 1, 1, 0, 0, 1, 8'h77, 0, 5'h02,  1, D, 0,  8'h77, 5'h02, 1, 0, 0));

    set_ctl(1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge fe_clk);
    check("reset_state", obs(), 35'd0, {35{1'b1}});
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Keep-alive: counter must not fire early, must hold at all-ones while disabled,
    // then fire TIME=FFFF as soon as timestamps are re-enabled, and restart from 0.
    run_vec(V("ka_disarm", 0, 0, 0, 0, 0, 0, 8'h00, 0, 5'h00, 0, D, 0, 8'h00, 5'h00, 0, 0, 0));
    run_vec(V("ka_arm",    0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00, 0, D, 0, 8'h00, 5'h00, 1, 0, 0));
    stray = 0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge fe_clk); @(negedge fe_clk);
      if (cap.O_capture_data_wr) stray++;
    end
    check_int("ka_no_early_strobe", stray, 0);
    cap.I_timestamps_disable = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge fe_clk); @(negedge fe_clk);
      if (cap.O_capture_data_wr) stray++;
    end
    check_int("ka_disabled_none", stray, 0);
    run_vec(V("ka_fire",    0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00, 1, T, 16'hFFFF, 8'h00, 5'h00, 1, 0, 0));
    run_vec(V("ka_restart", 3, 1, 0, 0, 0, 1, 8'h88, 0, 5'h00, 1, D, 3, 8'h88, 5'h00, 1, 0, 0));

    // Async reset while an event is parked behind a TIME entry.
    run_vec(V("rst_pend", 10, 1, 0, 0, 0, 1, 8'h99, 0, 5'h00, 1, T, 10, 8'h00, 5'h00, 1, 0, 0));
    #2 reset_n = 1'b0;
    #1 check("rst_async", obs(), 35'd0, {35{1'b1}});
    @(negedge fe_clk);
    reset_n = 1'b1;
    run_vec(V("rst_no_held", 0, 1, 0, 0, 0, 0, 8'h00, 0, 5'h00, 0, D, 0, 8'h00, 5'h00, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
